output_layer_mac: RTL and testbench
===================================

Name: output_layer_mac

Overview:
- Final dense layer of the digit-recognition engine. It computes 10 signed 32-bit output-node scores from the hidden-layer activations, using weights and biases streamed from a synchronous ROM.
- It drives the stage3 score array and the stage2_done flag that the argmax/one-hot stage consumes.
- Each run starts on a rising edge of the hidden layer's done flag.

Parameters:
N_IN, 32, number of hidden-layer activations (inputs per node)
N_OUT, 10, number of output nodes
IN_W, 16, signed activation width
WGT_W, 8, signed weight/bias ROM word width
ACC_W, 32, signed accumulator and output width
BIAS_SHIFT, 8, left shift applied to the sign-extended bias word
ADDR_W, 9, ROM address width (must cover N_OUT*N_IN+N_OUT words)

Ports:
clk  input  1  global clock
reset  input  1  asynchronous, active-high reset
hidden_in  input  signed IN_W x [0:N_IN-1]  hidden activations; upstream holds them stable while busy
stage1_done  input  1  hidden-layer done level; its rising edge starts a run
weight_rd  output  1  ROM read strobe
weight_addr  output  ADDR_W  ROM address
weight_data  input  signed WGT_W  ROM data, valid the cycle after weight_rd/weight_addr
stage3_out  output  signed ACC_W x [0:N_OUT-1]  output-node scores
stage2_done  output  1  level; high when all N_OUT scores are valid
busy  output  1  high while a run is in progress

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
  - Reset clears all state, internal counters and the stage1_done delay register.
  - Output reset values: stage3_out all 0, stage2_done=0, busy=0, weight_rd=0, weight_addr=0.
- Start detection: a delay register on stage1_done gives a rising-edge pulse.
  - The start edge E0 is the edge that samples stage1_done=1 with delay=0 while in IDLE.
  - At E0: busy<=1, stage2_done<=0, FSM goes to RUN.
  - Rising edges while busy are ignored. A level held high never retriggers.
- ROM address map:
  - weight for node n, input i: address n*N_IN+i.
  - bias for node n: address N_OUT*N_IN+n.
- Read stream: weight_rd is high for exactly N_OUT*(N_IN+1) consecutive cycles, starting the cycle after E0.
  - Per node n, in order: the bias address, then weight addresses i=0..N_IN-1.
  - Nodes run 0..N_OUT-1 with no gaps between them.
- Accumulate (one ROM latency cycle behind the reads):
  - Bias word: acc <= sign-extended weight_data << BIAS_SHIFT.
  - Weight word i: acc <= acc + hidden_in[i]*weight_data. Full-precision signed product, sign-extended to ACC_W.
  - Two's-complement wrap at ACC_W; no saturation.
- Store: on the edge that accumulates the last weight of node n, stage3_out[n] is written.
  - All other elements hold. Scores from a previous run remain until overwritten.
- Completion:
  - stage3_out[N_OUT-1], stage2_done<=1 and busy<=0 all update on edge E0+N_OUT*(N_IN+1)+1 (E0+331 at default parameters).
  - FSM returns to IDLE. stage2_done stays high until the next accepted start.
- FSM states:
  - IDLE -> RUN on start.
  - RUN: issues reads, counts node 0..N_OUT-1 and word 0..N_IN.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN: accumulates the final word and stores it, then -> IDLE.
- Reset mid-run: immediate abort, all outputs back to reset values. A later start runs the full length.
- Simultaneous events: a stage1_done rising edge on the same edge as completion is ignored, because the FSM is not yet in IDLE when the edge is sampled.

Test Plan:
1. Assert reset, release, idle 5 cycles -> stage3_out all 0, stage2_done=0, busy=0, weight_rd=0.
2. hidden_in all 1, all weights 1, biases 0, pulse stage1_done -> every stage3_out=32. weight_rd high exactly 330 cycles with addresses 320,0..31,321,32..63,…; stage2_done rises exactly at E0+331; busy high for 331 cycles.
3. hidden_in all -3, weights of node n = n-5, bias word of node n = 4n -> stage3_out[n]=1024n-96(n-5): out[0]=480, out[5]=5120, out[9]=8832.
4. hidden_in all -32768, all weights -128, biases 0 -> all outputs 134217728 with no wrap. Then biases 127 -> 134217728+32512=134250240.
5. Hold stage1_done high throughout, and add a second pulse at cycle 100 -> only one run. After completion, a new rising edge clears stage2_done at its E0 and re-asserts it 331 cycles later with identical results.
6. Assert reset at E0+100 mid-run -> all outputs cleared asynchronously. A subsequent start completes in 331 cycles with correct scores.

Source files
------------

// File: rtl/output_layer_mac_if.sv
// Weight/bias ROM read bus between the output-layer MAC (master) and its synchronous ROM (slave).
// Read data is valid the cycle after weight_rd/weight_addr.
interface output_layer_mac_if #(
    parameter int ADDR_W = 9,
    parameter int WGT_W  = 8
);
    logic                    weight_rd;
    logic [ADDR_W-1:0]       weight_addr;
    logic signed [WGT_W-1:0] weight_data;

    modport master (output weight_rd, output weight_addr, input weight_data);
    modport slave  (input weight_rd, input weight_addr, output weight_data);
endinterface

// File: rtl/output_layer_mac.sv
// Final dense layer: streams bias + weights per node from ROM and accumulates N_OUT signed scores.
// A run starts on a rising edge of stage1_done seen while idle.
module output_layer_mac #(
    parameter int N_IN       = 32,
    parameter int N_OUT      = 10,
    parameter int IN_W       = 16,
    parameter int WGT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int BIAS_SHIFT = 8,
    parameter int ADDR_W     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  hidden_in [0:N_IN-1],
    input  logic                    stage1_done,
    output_layer_mac_if.master      rom,
    output logic signed [ACC_W-1:0] stage3_out [0:N_OUT-1],
    output logic                    stage2_done,
    output logic                    busy
);
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WW = $clog2(N_IN + 1);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = IN_W + WGT_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(N_OUT * N_IN);
    localparam logic [NW-1:0]     LAST_NODE = NW'(N_OUT - 1);
    localparam logic [WW-1:0]     LAST_WORD = WW'(N_IN);

    logic [1:0]             state_q;
    logic                   stage1_q;
    // node_q/word_q tag the request currently on the ROM bus; word 0 is the bias
    logic [NW-1:0]          node_q;
    logic [WW-1:0]          word_q;
    // p_* tag the ROM word arriving on weight_data this cycle
    logic                   p_valid_q;
    logic [NW-1:0]          p_node_q;
    logic [WW-1:0]          p_word_q;
    logic signed [ACC_W-1:0] acc_q;

    logic                    start;
    logic [IW-1:0]           in_idx;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_next;

    assign start = stage1_done && !stage1_q && (state_q == IDLE);

    always_comb begin
        in_idx   = IW'(p_word_q - WW'(1));
        prod     = hidden_in[in_idx] * rom.weight_data;
        bias_ext = {{(ACC_W - WGT_W){rom.weight_data[WGT_W-1]}}, rom.weight_data};
        if (p_word_q == '0) begin
            acc_next = bias_ext << BIAS_SHIFT;
        end else begin
            acc_next = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            stage1_q        <= 1'b0;
            node_q          <= '0;
            word_q          <= '0;
            p_valid_q       <= 1'b0;
            p_node_q        <= '0;
            p_word_q        <= '0;
            acc_q           <= '0;
            rom.weight_rd   <= 1'b0;
            rom.weight_addr <= '0;
            stage2_done     <= 1'b0;
            busy            <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                stage3_out[k] <= '0;
            end
        end else begin
            stage1_q  <= stage1_done;
            p_valid_q <= rom.weight_rd;
            p_node_q  <= node_q;
            p_word_q  <= word_q;

            if (p_valid_q) begin
                acc_q <= acc_next;
                if (p_word_q == LAST_WORD) begin
                    stage3_out[p_node_q] <= acc_next;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q         <= RUN;
                        busy            <= 1'b1;
                        stage2_done     <= 1'b0;
                        node_q          <= '0;
                        word_q          <= '0;
                        rom.weight_rd   <= 1'b1;
                        rom.weight_addr <= BIAS_BASE;
                    end
                end
                RUN: begin
                    if (word_q == LAST_WORD) begin
                        word_q <= '0;
                        if (node_q == LAST_NODE) begin
                            rom.weight_rd <= 1'b0;
                            state_q       <= DRAIN;
                        end else begin
                            node_q          <= node_q + NW'(1);
                            rom.weight_addr <= BIAS_BASE + ADDR_W'(node_q) + ADDR_W'(1);
                        end
                    end else begin
                        // next request is weight index word_q of the current node
                        word_q          <= word_q + WW'(1);
                        rom.weight_addr <= ADDR_W'(node_q) * ADDR_W'(N_IN) + ADDR_W'(word_q);
                    end
                end
                DRAIN: begin
                    if (p_valid_q && p_word_q == LAST_WORD && p_node_q == LAST_NODE) begin
                        state_q     <= IDLE;
                        stage2_done <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_layer_mac.sv
// Randomised self-checking bench for output_layer_mac against a cycle-scheduled behavioural model.
module tb_output_layer_mac;
    localparam int N_IN    = 32;
    localparam int N_OUT   = 10;
    localparam int ROM_N   = N_OUT * N_IN + N_OUT;
    localparam int RUN_LEN = N_OUT * (N_IN + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stage1_done = 1'b0;
    logic signed [15:0] hidden [0:N_IN-1];
    logic signed [31:0] stage3_out [0:N_OUT-1];
    logic stage2_done, busy;
    logic signed [7:0] rom_mem [0:ROM_N-1];

    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int busy_cnt = 0;
    bit chk_en = 1'b0;

    output_layer_mac_if #(.ADDR_W(9), .WGT_W(8)) bus ();

    output_layer_mac dut (
        .clk        (clk),
        .reset      (reset),
        .hidden_in  (hidden),
        .stage1_done(stage1_done),
        .rom        (bus),
        .stage3_out (stage3_out),
        .stage2_done(stage2_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.weight_rd) bus.weight_data <= rom_mem[bus.weight_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: scores from plain arithmetic, timing from the documented schedule
    bit m_busy = 0, m_done = 0, s1_prev = 0;
    int m_t = 0;
    int m_out [0:N_OUT-1];
    int m_exp [0:N_OUT-1];

    function automatic int score(int n);
        int acc;
        acc = int'(rom_mem[N_OUT * N_IN + n]) <<< 8;
        for (int i = 0; i < N_IN; i++) acc += int'(hidden[i]) * int'(rom_mem[n * N_IN + i]);
        return acc;
    endfunction

    function automatic int item_addr(int j);
        int n, w;
        n = j / (N_IN + 1);
        w = j % (N_IN + 1);
        return (w == 0) ? N_OUT * N_IN + n : n * N_IN + w - 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_t = 0; s1_prev = 0;
            for (int n = 0; n < N_OUT; n++) m_out[n] = 0;
        end else begin
            if (m_busy) begin
                m_t++;
                for (int n = 0; n < N_OUT; n++)
                    if (m_t == (n + 1) * (N_IN + 1) + 1) m_out[n] = m_exp[n];
                if (m_t == RUN_LEN + 1) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (stage1_done && !s1_prev) begin
                m_busy = 1; m_done = 0; m_t = 0;
                for (int n = 0; n < N_OUT; n++) m_exp[n] = score(n);
            end
            s1_prev = stage1_done;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rd;
            exp_rd = m_busy && (m_t < RUN_LEN);
            chk("busy", int'(busy), int'(m_busy));
            chk("stage2_done", int'(stage2_done), int'(m_done));
            chk("weight_rd", int'(bus.weight_rd), int'(exp_rd));
            if (exp_rd) chk("weight_addr", int'(bus.weight_addr), item_addr(m_t));
            for (int n = 0; n < N_OUT; n++)
                chk($sformatf("stage3_out[%0d]", n), int'(stage3_out[n]), m_out[n]);
            if (bus.weight_rd) rd_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!stage2_done && c < 400) begin
            tick(1);
            c++;
        end
        chk("run_completes", int'(stage2_done), 1);
    endtask

    task automatic run_once();
        rd_cnt = 0;
        busy_cnt = 0;
        stage1_done = 1'b1;
        tick(1);
        stage1_done = 1'b0;
        wait_done();
    endtask

    task automatic load(input int h, input int wfn, input int bfn);
        // wfn/bfn: 0 = constant value given, 1 = test-3 pattern
        for (int i = 0; i < N_IN; i++) hidden[i] = 16'(h);
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) rom_mem[n * N_IN + i] = 8'((wfn == 1) ? n - 5 : wfn);
            rom_mem[N_OUT * N_IN + n] = 8'((bfn == 1) ? 4 * n : bfn);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load(0, 0, 0);
        #1 reset = 1'b1;
        #20 chk_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        tick(5);
        chk("reset_out0", int'(stage3_out[0]), 0);
        chk("reset_done", int'(stage2_done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd", int'(bus.weight_rd), 0);
        chk("reset_addr", int'(bus.weight_addr), 0);

        load(1, 1, 0);
        for (int n = 0; n < N_OUT; n++)
            for (int i = 0; i < N_IN; i++) rom_mem[n * N_IN + i] = 8'sd1;
        run_once();
        chk("t2_rd_cycles", rd_cnt, 330);
        chk("t2_busy_cycles", busy_cnt, 331);
        chk("t2_out0", int'(stage3_out[0]), 32);
        chk("t2_out9", int'(stage3_out[9]), 32);

        load(-3, 1, 1);
        run_once();
        chk("t3_out0", int'(stage3_out[0]), 480);
        chk("t3_out5", int'(stage3_out[5]), 5120);
        chk("t3_out9", int'(stage3_out[9]), 8832);

        load(-32768, -128, 0);
        run_once();
        chk("t4_out3", int'(stage3_out[3]), 134217728);
        load(-32768, -128, 127);
        run_once();
        chk("t4b_out7", int'(stage3_out[7]), 134250240);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_IN; i++) hidden[i] = 16'($urandom);
            for (int a = 0; a < ROM_N; a++) rom_mem[a] = 8'($urandom);
            run_once();
            tick($urandom_range(0, 3));
        end

        load(-3, 1, 1);
        rd_cnt = 0;
        busy_cnt = 0;
        stage1_done = 1'b1;
        tick(100);
        stage1_done = 1'b0;
        tick(1);
        stage1_done = 1'b1;
        wait_done();
        tick(20);
        chk("t5_single_run", busy_cnt, 331);
        chk("t5_done_held", int'(stage2_done), 1);
        stage1_done = 1'b0;
        tick(1);
        stage1_done = 1'b1;
        tick(1);
        chk("t5_done_cleared", int'(stage2_done), 0);
        stage1_done = 1'b0;
        wait_done();
        chk("t5_out5", int'(stage3_out[5]), 5120);

        stage1_done = 1'b1;
        tick(1);
        stage1_done = 1'b0;
        tick(99);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_rd", int'(bus.weight_rd), 0);
        chk("t6_addr", int'(bus.weight_addr), 0);
        chk("t6_out9", int'(stage3_out[9]), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        run_once();
        chk("t6_busy_cycles", busy_cnt, 331);
        chk("t6_out9_after", int'(stage3_out[9]), 8832);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
